alu_cmd_driver: RTL and testbench
=================================

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameters: DEPTH, default 4, command FIFO entries (power of 2, min 2); WIDTH, default 8, operand/result width.
REQ-002 clk  input  1  single clock; all flops rise-edge triggered.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered by the host.
REQ-005 cmd_ready  output  1  FIFO not full; a command is accepted when cmd_valid and cmd_ready are both high at an edge.
REQ-006 cmd_op  input  3  op code: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR.
REQ-007 cmd_load  input  1  1 loads cmd_a into the ALU accumulator; 0 persists the previous result as the accumulator.
REQ-008 cmd_a, cmd_b  input  WIDTH each  accumulator operand and second operand.
REQ-009 alu_on  output  1  ALU power/enable.
REQ-010 alu_in_sel  output  3  one-hot ALU input select: bit2 persist, bit1 load, bit0 reset.
REQ-011 alu_num1, alu_num2  output  WIDTH each  ALU operands.
REQ-012 alu_out_sel  output  7  one-hot ALU op select: bit6 AND, bit5 OR, bit4 NOT, bit3 XOR, bit2 ADD, bit1 SUB, bit0 MULT.
REQ-013 alu_result  input  WIDTH  ALU output value (combinational from ALU operand registers).
REQ-014 alu_state  input  2  ALU FSM state: 00 off, 01 ready, 10 run, 11 run_error.
REQ-015 rsp_valid  output  1  result available; rsp_ready  input  1  host accepts the result.
REQ-016 rsp_data  output  WIDTH  captured result; rsp_error  output  1  overflow/error flag for that result.
REQ-017 busy  output  1  high whenever the FSM is outside IDLE or the FIFO is non-empty.

Function
REQ-018 Commands SHALL be stored in a DEPTH-entry FIFO (op, load, a, b); cmd_ready = !full; a simultaneous push and pop while full SHALL NOT be accepted (cmd_ready stays low when full).
REQ-019 FSM states: IDLE, POWERUP, ISSUE, CAPTURE, RESPOND.
REQ-020 IDLE: alu_on=0; alu_in_sel=100 (persist); on FIFO non-empty go to POWERUP.
REQ-021 POWERUP: alu_on=1; move to ISSUE on the first edge where alu_state=01; if alu_state is not 01 within 15 cycles, pop the head entry, go to RESPOND with rsp_error=1 and rsp_data=0.
REQ-022 ISSUE (exactly 1 cycle): pop the FIFO head; drive alu_num1=cmd_a, alu_num2=cmd_b, alu_out_sel one-hot per cmd_op, alu_in_sel=010 if cmd_load else 100; op 7 drives alu_in_sel=001 and alu_out_sel=0000000.
REQ-023 CAPTURE (exactly 1 cycle): alu_in_sel=100, operand/op outputs held; at the end of the cycle register rsp_data=alu_result (op 7: rsp_data=0) and rsp_error=(alu_state==11).
REQ-024 RESPOND: rsp_valid=1 with rsp_data/rsp_error held stable until rsp_valid&rsp_ready; then go to ISSUE if the FIFO is non-empty (alu_on stays 1), else IDLE.
REQ-025 Command-to-rsp_valid latency SHALL be 3 cycles from ISSUE entry when the ALU is already ready (ISSUE, CAPTURE, rsp_valid in the third cycle).
REQ-026 rsp_valid SHALL NOT depend combinationally on rsp_ready; rsp_ready high in the first RESPOND cycle completes the transfer at that edge.
REQ-027 After a response with rsp_error=1, the next command SHALL be issued only after alu_state returns to 01 (re-enter POWERUP instead of ISSUE).
REQ-028 Arithmetic is performed by the ALU only; this block performs no width conversion and truncates nothing.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; push and pop in the same cycle when neither full nor empty keeps the count unchanged.

Reset
REQ-030 While rst=0: FSM=IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0, alu_on=0, alu_in_sel=100, alu_out_sel=0, alu_num1=alu_num2=0, busy=0.
REQ-031 Reset asserted mid-operation SHALL abort immediately; queued and in-flight commands are discarded, no response is produced.

Verification
REQ-032 Load ADD: cmd(op4, load=1, a=8'h05, b=8'h03), ALU model ready -> alu_in_sel=010, alu_out_sel=0000100 in ISSUE; rsp_data=8'h08, rsp_error=0, 3 cycles later.
REQ-033 Persist chain: follow REQ-032 with cmd(op5, load=0, b=8'h02) -> alu_in_sel=100 in ISSUE, rsp_data=8'h06.
REQ-034 Overflow: MULT a=8'h20, b=8'h10, model alu_state=11 in CAPTURE -> rsp_error=1; next command waits in POWERUP until alu_state=01.
REQ-035 Backpressure/full: push 5 commands with rsp_ready=0 and DEPTH=4 -> cmd_ready=0 after 4 accepted (1 in RESPOND); responses emerge in order once rsp_ready=1.
REQ-036 Timeout: alu_state held 00 -> after 15 POWERUP cycles rsp_valid=1, rsp_error=1, rsp_data=0.
REQ-037 Reset mid-CAPTURE: rst=0 for 1 cycle -> all outputs at REQ-030 values, no rsp_valid afterwards.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//
// Queues host ALU commands in a small FIFO and sequences them into an external
// ALU. The ALU is powered up when work arrives, each command is issued for one
// cycle, the ALU result and error status are captured one cycle later, and the
// result is presented to the host on a valid/ready response channel. A
// power-up that never reaches the ALU "ready" state is abandoned after a
// bounded wait and reported as an error response. After any error response
// the ALU is walked back through power-up before the next command.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   cmd_valid    : host offers a command
//   cmd_ready    : FIFO has room (command taken when valid & ready)
//   cmd_op       : 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR
//   cmd_load     : 1 = load cmd_a as accumulator, 0 = keep previous result
//   cmd_a/cmd_b  : accumulator operand / second operand
//   alu_on       : ALU power enable
//   alu_in_sel   : one-hot {persist, load, reset}
//   alu_num1/2   : ALU operands
//   alu_out_sel  : one-hot {AND, OR, NOT, XOR, ADD, SUB, MULT}
//   alu_result   : ALU result (combinational from ALU operand registers)
//   alu_state    : ALU state 00 off, 01 ready, 10 run, 11 run_error
//   rsp_valid    : response available
//   rsp_ready    : host accepts the response
//   rsp_data     : captured result
//   rsp_error    : error flag for that result
//   busy         : FSM outside IDLE or commands queued
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_state,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 + 2 * WIDTH;

    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_RESET   = 3'b001;
    localparam logic [1:0] ALU_READY  = 2'b01;
    localparam logic [1:0] ALU_ERROR  = 2'b11;
    localparam logic [2:0] OP_CLEAR   = 3'd7;
    // Last cycle index of the power-up wait (15 cycles: indices 0..14).
    localparam logic [3:0] TMO_LAST   = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POWERUP = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESPOND = 3'd4
    } state_t;

    // Op code to one-hot ALU operation select; CLEAR selects no operation.
    function automatic logic [6:0] op_onehot(input logic [2:0] op);
        case (op)
            3'd0:    op_onehot = 7'b1000000;
            3'd1:    op_onehot = 7'b0100000;
            3'd2:    op_onehot = 7'b0010000;
            3'd3:    op_onehot = 7'b0001000;
            3'd4:    op_onehot = 7'b0000100;
            3'd5:    op_onehot = 7'b0000010;
            3'd6:    op_onehot = 7'b0000001;
            default: op_onehot = 7'b0000000;
        endcase
    endfunction

    // ALU input select for the issue cycle.
    function automatic logic [2:0] issue_in_sel(input logic [2:0] op, input logic load);
        if (op == OP_CLEAR) begin
            issue_in_sel = IN_RESET;
        end else if (load) begin
            issue_in_sel = IN_LOAD;
        end else begin
            issue_in_sel = IN_PERSIST;
        end
    endfunction

    // FIFO storage and bookkeeping
    logic [EW-1:0] fifo_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    logic [EW-1:0]    head_s;
    logic [2:0]       head_op_s;
    logic             head_load_s;
    logic [WIDTH-1:0] head_a_s;
    logic [WIDTH-1:0] head_b_s;

    // FSM and output registers
    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       tmo_r;
    logic [3:0]       tmo_nxt_s;
    logic             need_pwr_r;
    logic             need_pwr_nxt_s;
    logic [2:0]       op_r;
    logic [2:0]       op_nxt_s;
    logic             alu_on_r;
    logic             alu_on_nxt_s;
    logic [2:0]       in_sel_r;
    logic [2:0]       in_sel_nxt_s;
    logic [6:0]       out_sel_r;
    logic [6:0]       out_sel_nxt_s;
    logic [WIDTH-1:0] num1_r;
    logic [WIDTH-1:0] num1_nxt_s;
    logic [WIDTH-1:0] num2_r;
    logic [WIDTH-1:0] num2_nxt_s;
    logic             rsp_valid_r;
    logic             rsp_valid_nxt_s;
    logic [WIDTH-1:0] rsp_data_r;
    logic [WIDTH-1:0] rsp_data_nxt_s;
    logic             rsp_error_r;
    logic             rsp_error_nxt_s;
    logic             cmd_ready_r;
    logic             busy_r;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == CW'(0));
    // Refusing pushes while full also covers the full + pop case.
    assign push_s  = cmd_valid && !full_s;

    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign head_op_s   = head_s[EW-1 -: 3];
    assign head_load_s = head_s[2*WIDTH];
    assign head_a_s    = head_s[2*WIDTH-1 -: WIDTH];
    assign head_b_s    = head_s[WIDTH-1:0];

    // Next FIFO occupancy from this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage write (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_op, cmd_load, cmd_a, cmd_b};
        end
    end

    // FIFO pointers and count; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so the registered outputs line up with the FSM state.
    always_comb begin
        state_nxt_s     = state_r;
        pop_s           = 1'b0;
        tmo_nxt_s       = tmo_r;
        need_pwr_nxt_s  = need_pwr_r;
        op_nxt_s        = op_r;
        alu_on_nxt_s    = alu_on_r;
        in_sel_nxt_s    = IN_PERSIST;
        out_sel_nxt_s   = out_sel_r;
        num1_nxt_s      = num1_r;
        num2_nxt_s      = num2_r;
        rsp_valid_nxt_s = 1'b0;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_error_nxt_s = rsp_error_r;
        case (state_r)
            ST_IDLE: begin
                alu_on_nxt_s = 1'b0;
                if (!empty_s) begin
                    state_nxt_s  = ST_POWERUP;
                    alu_on_nxt_s = 1'b1;
                    tmo_nxt_s    = 4'd0;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_POWERUP: begin
                alu_on_nxt_s = 1'b1;
                if (alu_state == ALU_READY) begin
                    state_nxt_s    = ST_ISSUE;
                    need_pwr_nxt_s = 1'b0;
                    op_nxt_s       = head_op_s;
                    num1_nxt_s     = head_a_s;
                    num2_nxt_s     = head_b_s;
                    out_sel_nxt_s  = op_onehot(head_op_s);
                    in_sel_nxt_s   = issue_in_sel(head_op_s, head_load_s);
                end else if (tmo_r == TMO_LAST) begin
                    // Give up on this command and report it as failed.
                    pop_s           = 1'b1;
                    state_nxt_s     = ST_RESPOND;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_data_nxt_s  = {WIDTH{1'b0}};
                    rsp_error_nxt_s = 1'b1;
                    need_pwr_nxt_s  = 1'b1;
                end else begin
                    tmo_nxt_s = tmo_r + 4'd1;
                end
            end
            ST_ISSUE: begin
                pop_s       = 1'b1;
                state_nxt_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nxt_s     = ST_RESPOND;
                rsp_valid_nxt_s = 1'b1;
                if (op_r == OP_CLEAR) begin
                    rsp_data_nxt_s = {WIDTH{1'b0}};
                end else begin
                    rsp_data_nxt_s = alu_result;
                end
                rsp_error_nxt_s = (alu_state == ALU_ERROR);
                need_pwr_nxt_s  = (alu_state == ALU_ERROR);
            end
            ST_RESPOND: begin
                rsp_valid_nxt_s = 1'b1;
                if (rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    if (empty_s) begin
                        state_nxt_s   = ST_IDLE;
                        alu_on_nxt_s  = 1'b0;
                        out_sel_nxt_s = 7'b0000000;
                        num1_nxt_s    = {WIDTH{1'b0}};
                        num2_nxt_s    = {WIDTH{1'b0}};
                    end else if (need_pwr_r) begin
                        // After an error the ALU must report ready again first.
                        state_nxt_s = ST_POWERUP;
                        tmo_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s   = ST_ISSUE;
                        op_nxt_s      = head_op_s;
                        num1_nxt_s    = head_a_s;
                        num2_nxt_s    = head_b_s;
                        out_sel_nxt_s = op_onehot(head_op_s);
                        in_sel_nxt_s  = issue_in_sel(head_op_s, head_load_s);
                    end
                end else begin
                    state_nxt_s = ST_RESPOND;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                alu_on_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            tmo_r       <= 4'd0;
            need_pwr_r  <= 1'b0;
            op_r        <= 3'd0;
            alu_on_r    <= 1'b0;
            in_sel_r    <= IN_PERSIST;
            out_sel_r   <= 7'b0000000;
            num1_r      <= {WIDTH{1'b0}};
            num2_r      <= {WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_error_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            tmo_r       <= tmo_nxt_s;
            need_pwr_r  <= need_pwr_nxt_s;
            op_r        <= op_nxt_s;
            alu_on_r    <= alu_on_nxt_s;
            in_sel_r    <= in_sel_nxt_s;
            out_sel_r   <= out_sel_nxt_s;
            num1_r      <= num1_nxt_s;
            num2_r      <= num2_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_error_r <= rsp_error_nxt_s;
            cmd_ready_r <= (count_nxt_s != CW'(DEPTH));
            busy_r      <= (state_nxt_s != ST_IDLE) || (count_nxt_s != CW'(0));
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign alu_on      = alu_on_r;
    assign alu_in_sel  = in_sel_r;
    assign alu_out_sel = out_sel_r;
    assign alu_num1    = num1_r;
    assign alu_num2    = num2_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_error   = rsp_error_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
//
// Directed bench for alu_cmd_driver with a small behavioural ALU: operand
// registers latch the driver outputs every clock and the result is a
// combinational function of them. "Persist" uses acc_hold, the previous
// result, which the stimulus sets from its own hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic         cmd_load;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         alu_on;
    logic [2:0]   alu_in_sel;
    logic [W-1:0] alu_num1;
    logic [W-1:0] alu_num2;
    logic [6:0]   alu_out_sel;
    logic [W-1:0] alu_result;
    logic [1:0]   alu_state;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_error;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Behavioural ALU state
    logic [W-1:0] a_q = 8'h00;
    logic [W-1:0] b_q = 8'h00;
    logic [6:0]   op_q = 7'b0000000;
    logic [2:0]   sel_q = 3'b100;
    logic [W-1:0] acc_hold = 8'h00;
    logic [W-1:0] acc_src;

    always #5 clk = ~clk;

    alu_cmd_driver #(.DEPTH(4), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_load    (cmd_load),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_on      (alu_on),
        .alu_in_sel  (alu_in_sel),
        .alu_num1    (alu_num1),
        .alu_num2    (alu_num2),
        .alu_out_sel (alu_out_sel),
        .alu_result  (alu_result),
        .alu_state   (alu_state),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .busy        (busy)
    );

    // ALU operand registers
    always_ff @(posedge clk) begin
        a_q   <= alu_num1;
        b_q   <= alu_num2;
        op_q  <= alu_out_sel;
        sel_q <= alu_in_sel;
    end

    // ALU result
    always_comb begin
        if (sel_q == 3'b010) begin
            acc_src = a_q;
        end else if (sel_q == 3'b001) begin
            acc_src = 8'h00;
        end else begin
            acc_src = acc_hold;
        end
        case (op_q)
            7'b1000000: alu_result = acc_src & b_q;
            7'b0100000: alu_result = acc_src | b_q;
            7'b0010000: alu_result = ~acc_src;
            7'b0001000: alu_result = acc_src ^ b_q;
            7'b0000100: alu_result = acc_src + b_q;
            7'b0000010: alu_result = acc_src - b_q;
            7'b0000001: alu_result = acc_src * b_q;
            default:    alu_result = 8'hFF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [2:0] op, input logic ld, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_load  = ld;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a response, checks it, and steps past the handshake.
    task automatic get_rsp(input string tag, input logic [7:0] exp_d, input logic exp_e);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_d});
        chk({tag, "_error"}, {31'd0, rsp_error}, {31'd0, exp_e});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_load  = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b1;
        alu_state = 2'b01;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_alu_on", {31'd0, alu_on}, 32'd0);
        chk("rst_in_sel", {29'd0, alu_in_sel}, 32'b100);
        chk("rst_out_sel", {25'd0, alu_out_sel}, 32'd0);
        chk("rst_num1", {24'd0, alu_num1}, 32'd0);
        chk("rst_num2", {24'd0, alu_num2}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Load ADD followed by persist SUB
        push(3'd4, 1'b1, 8'h05, 8'h03);
        push(3'd5, 1'b0, 8'h00, 8'h02);
        chk("pwr_alu_on", {31'd0, alu_on}, 32'd1);
        chk("pwr_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("add_in_sel", {29'd0, alu_in_sel}, 32'b010);
        chk("add_out_sel", {25'd0, alu_out_sel}, 32'b0000100);
        chk("add_num1", {24'd0, alu_num1}, 32'h05);
        chk("add_num2", {24'd0, alu_num2}, 32'h03);
        @(negedge clk);
        chk("cap_in_sel", {29'd0, alu_in_sel}, 32'b100);
        chk("cap_no_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("add_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_data", {24'd0, rsp_data}, 32'h08);
        chk("add_error", {31'd0, rsp_error}, 32'd0);
        acc_hold = 8'h08;
        @(negedge clk);
        chk("sub_in_sel", {29'd0, alu_in_sel}, 32'b100);
        chk("sub_out_sel", {25'd0, alu_out_sel}, 32'b0000010);
        chk("sub_num2", {24'd0, alu_num2}, 32'h02);
        get_rsp("sub", 8'h06, 1'b0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_alu_on", {31'd0, alu_on}, 32'd0);

        // CLEAR
        push(3'd7, 1'b1, 8'h55, 8'h66);
        repeat (2) @(negedge clk);
        chk("clr_in_sel", {29'd0, alu_in_sel}, 32'b001);
        chk("clr_out_sel", {25'd0, alu_out_sel}, 32'd0);
        get_rsp("clr", 8'h00, 1'b0);

        // Overflow and recovery through POWERUP
        rsp_ready = 1'b0;
        push(3'd6, 1'b1, 8'h20, 8'h10);
        repeat (2) @(negedge clk);
        chk("mul_out_sel", {25'd0, alu_out_sel}, 32'b0000001);
        @(negedge clk);
        alu_state = 2'b11;
        @(negedge clk);
        chk("ovf_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ovf_error", {31'd0, rsp_error}, 32'd1);
        chk("ovf_data", {24'd0, rsp_data}, 32'h00);
        push(3'd4, 1'b1, 8'h01, 8'h02);
        chk("ovf_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ovf_hold_error", {31'd0, rsp_error}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rec_no_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rec_alu_on", {31'd0, alu_on}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rec_wait_num1", {24'd0, alu_num1}, 32'h20);
        chk("rec_wait_valid", {31'd0, rsp_valid}, 32'd0);
        alu_state = 2'b01;
        get_rsp("rec", 8'h03, 1'b0);

        // Backpressure: FIFO fills while one response waits
        rsp_ready = 1'b0;
        push(3'd0, 1'b1, 8'h3C, 8'h0F);
        push(3'd1, 1'b1, 8'h3C, 8'h0F);
        push(3'd2, 1'b1, 8'h3C, 8'h0F);
        push(3'd3, 1'b1, 8'h3C, 8'h0F);
        push(3'd4, 1'b1, 8'h3C, 8'h0F);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_valid", {31'd0, rsp_valid}, 32'd1);
        cmd_op    = 3'd5;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("full_still", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        get_rsp("q_and", 8'h0C, 1'b0);
        get_rsp("q_or", 8'h3F, 1'b0);
        get_rsp("q_not", 8'hC3, 1'b0);
        get_rsp("q_xor", 8'h33, 1'b0);
        get_rsp("q_add", 8'h4B, 1'b0);
        repeat (4) @(negedge clk);
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Power-up timeout
        alu_state = 2'b00;
        rsp_ready = 1'b0;
        push(3'd4, 1'b1, 8'h01, 8'h01);
        repeat (15) @(negedge clk);
        chk("tmo_wait", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("tmo_valid", {31'd0, rsp_valid}, 32'd1);
        chk("tmo_error", {31'd0, rsp_error}, 32'd1);
        chk("tmo_data", {24'd0, rsp_data}, 32'h00);
        rsp_ready = 1'b1;
        alu_state = 2'b01;
        @(negedge clk);

        // Reset during CAPTURE
        push(3'd4, 1'b1, 8'h09, 8'h09);
        push(3'd4, 1'b1, 8'h07, 8'h07);
        repeat (2) @(negedge clk);
        chk("pre_rst_on", {31'd0, alu_on}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_alu_on", {31'd0, alu_on}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_in_sel", {29'd0, alu_in_sel}, 32'b100);
        chk("mid_rst_out_sel", {25'd0, alu_out_sel}, 32'd0);
        chk("mid_rst_num1", {24'd0, alu_num1}, 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) begin
                seen++;
            end
        end
        chk("post_rst_quiet", seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
